square_cursor_ctrl: RTL



---
 rtl/square_cursor_ctrl_if.sv | 21 ++
 rtl/square_cursor_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/square_cursor_ctrl_if.sv
// Cursor control bus: buttons and encoder in, square position and colour out.
// Inputs drive the controller; position, colour and move pulse come back.
interface square_cursor_ctrl_if;
    logic [4:0] iBTN;
    logic       iKnobStep;
    logic       iKnobDir;
    logic [7:0] oXPos;
    logic [7:0] oYPos;
    logic [2:0] oColor;
    logic       oMoved;

    modport master (
        output iBTN, iKnobStep, iKnobDir,
        input  oXPos, oYPos, oColor, oMoved
    );

    modport slave (
        input  iBTN, iKnobStep, iKnobDir,
        output oXPos, oYPos, oColor, oMoved
    );
endinterface

// File: rtl/square_cursor_ctrl.sv
// Square cursor: button steps with hold auto-repeat, saturating moves, encoder colour.
// Ports: Clock, Reset (async, active-high), bus (slave side of square_cursor_ctrl_if).
module square_cursor_ctrl #(
    parameter int STEP          = 8,
    parameter int SQUARE        = 32,
    parameter int HOLD_DELAY    = 12_500_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int CW            = 24
) (
    input  logic                 Clock,
    input  logic                 Reset,
    square_cursor_ctrl_if.slave  bus
);

    localparam int XYMAX  = 256 - SQUARE;
    localparam int CENTER = XYMAX / 2;

    localparam logic [8:0]    MAX9      = 9'(XYMAX);
    localparam logic [8:0]    STEP9     = 9'(STEP);
    localparam logic [7:0]    CTR8      = 8'(CENTER);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    state_t        state, state_n;
    logic [4:0]    rBtn;
    logic [4:0]    held, held_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] last;
    logic          step;

    logic [7:0] x, y, x_n, y_n;
    logic [2:0] color, color_n;
    logic       moved, moved_n;

    // Widened to 9 bits so the add cannot wrap before clamping.
    function automatic logic [7:0] inc_sat(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + STEP9;
        return (s > MAX9) ? MAX9[7:0] : s[7:0];
    endfunction

    function automatic logic [7:0] dec_sat(input logic [7:0] v);
        return ({1'b0, v} < STEP9) ? 8'd0 : v - STEP9[7:0];
    endfunction

    assign last = (state == DELAY) ? HOLD_LAST : REP_LAST;

    always_comb begin
        state_n = state;
        held_n  = held;
        cnt_n   = cnt;
        step    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rBtn != '0) begin
                    step    = 1'b1;
                    held_n  = rBtn;
                    cnt_n   = '0;
                    state_n = DELAY;
                end
            end
            DELAY, REPEAT: begin
                if (rBtn == '0) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (rBtn != held) begin
                    // New pattern restarts the hold delay.
                    step    = 1'b1;
                    held_n  = rBtn;
                    cnt_n   = '0;
                    state_n = DELAY;
                end else if (cnt == last) begin
                    step    = 1'b1;
                    cnt_n   = '0;
                    state_n = REPEAT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // rBtn bits: [4]UP [3]DOWN [2]LEFT [1]RIGHT [0]CNTR
    always_comb begin
        x_n = x;
        y_n = y;
        if (step) begin
            if (rBtn[0]) begin
                x_n = CTR8;
                y_n = CTR8;
            end else begin
                unique case (rBtn[2:1])
                    2'b01:   x_n = inc_sat(x);
                    2'b10:   x_n = dec_sat(x);
                    default: x_n = x;
                endcase
                unique case (rBtn[4:3])
                    2'b01:   y_n = inc_sat(y);
                    2'b10:   y_n = dec_sat(y);
                    default: y_n = y;
                endcase
            end
        end
        moved_n = (x_n != x) || (y_n != y);
    end

    // Colour cycles through 1..7, skipping black.
    always_comb begin
        color_n = color;
        if (bus.iKnobStep) begin
            if (bus.iKnobDir) begin
                color_n = (color == 3'd7) ? 3'd1 : color + 3'd1;
            end else begin
                color_n = (color == 3'd1) ? 3'd7 : color - 3'd1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            rBtn  <= '0;
            held  <= '0;
            cnt   <= '0;
            x     <= CTR8;
            y     <= CTR8;
            color <= 3'b100;
            moved <= 1'b0;
        end else begin
            state <= state_n;
            rBtn  <= bus.iBTN;
            held  <= held_n;
            cnt   <= cnt_n;
            x     <= x_n;
            y     <= y_n;
            color <= color_n;
            moved <= moved_n;
        end
    end

    assign bus.oXPos  = x;
    assign bus.oYPos  = y;
    assign bus.oColor = color;
    assign bus.oMoved = moved;

endmodule
